// File: rtl/eeg_oram_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : eeg_oram_acc_if
// Brief    : PSUM input stream, ORAM read/write channels and status of one
//            ORAM accumulator lane.
// Revision : 1.0  initial release
// ============================================================================
interface eeg_oram_acc_if #(
    parameter int OMUX_ADD_AW = 8,
    parameter int ORAM_DAT_DW = 8,
    parameter int PSUM_DW     = 12,
    parameter int CNT_DW      = 16
) ();
    logic                   PSUM_VLD;
    logic                   PSUM_RDY;
    logic [OMUX_ADD_AW-1:0] PSUM_ADD;
    logic [PSUM_DW-1:0]     PSUM_DAT;
    logic                   PSUM_CLR;
    logic                   PSUM_LST;

    logic                   ORAM_ADD_VLD;
    logic                   ORAM_ADD_LST;
    logic                   ORAM_ADD_RDY;
    logic [OMUX_ADD_AW-1:0] ORAM_ADD_ADD;

    logic                   ORAM_DAT_VLD;
    logic                   ORAM_DAT_LST;
    logic                   ORAM_DAT_RDY;
    logic [ORAM_DAT_DW-1:0] ORAM_DAT_DAT;

    logic                   ORAM_DIN_VLD;
    logic                   ORAM_DIN_RDY;
    logic [OMUX_ADD_AW-1:0] ORAM_DIN_ADD;
    logic [ORAM_DAT_DW-1:0] ORAM_DIN_DAT;

    logic                   ACC_DONE;
    logic [CNT_DW-1:0]      ACC_CNT;

    // Accumulator side
    modport slave (
        input  PSUM_VLD, PSUM_ADD, PSUM_DAT, PSUM_CLR, PSUM_LST,
        input  ORAM_ADD_RDY, ORAM_DAT_VLD, ORAM_DAT_LST, ORAM_DAT_DAT, ORAM_DIN_RDY,
        output PSUM_RDY, ORAM_ADD_VLD, ORAM_ADD_LST, ORAM_ADD_ADD, ORAM_DAT_RDY,
        output ORAM_DIN_VLD, ORAM_DIN_ADD, ORAM_DIN_DAT, ACC_DONE, ACC_CNT
    );

    // PE array / RAM lane side
    modport master (
        output PSUM_VLD, PSUM_ADD, PSUM_DAT, PSUM_CLR, PSUM_LST,
        output ORAM_ADD_RDY, ORAM_DAT_VLD, ORAM_DAT_LST, ORAM_DAT_DAT, ORAM_DIN_RDY,
        input  PSUM_RDY, ORAM_ADD_VLD, ORAM_ADD_LST, ORAM_ADD_ADD, ORAM_DAT_RDY,
        input  ORAM_DIN_VLD, ORAM_DIN_ADD, ORAM_DIN_DAT, ACC_DONE, ACC_CNT
    );
endinterface
`default_nettype wire

// File: rtl/eeg_oram_acc.sv
`default_nettype none
// ============================================================================
// Module   : eeg_oram_acc
// Brief    : Read-modify-write saturating partial-sum accumulator for one
//            ORAM lane (clear path writes the psum directly, no read).
// Revision : 1.0  initial release
// ============================================================================
module eeg_oram_acc #(
    parameter int OMUX_ADD_AW = 8,
    parameter int ORAM_DAT_DW = 8,
    parameter int PSUM_DW     = 12,
    parameter int CNT_DW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    eeg_oram_acc_if.slave bus
);
    localparam int c_SW = ((PSUM_DW > ORAM_DAT_DW) ? PSUM_DW : ORAM_DAT_DW) + 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RD   = 2'd1;
    localparam logic [1:0] c_ST_WT   = 2'd2;
    localparam logic [1:0] c_ST_WR   = 2'd3;

    logic [1:0]             r_state;
    logic [OMUX_ADD_AW-1:0] r_add;
    logic [PSUM_DW-1:0]     r_dat;
    logic                   r_lst;
    logic [ORAM_DAT_DW-1:0] r_wdat;
    logic                   r_psum_rdy;
    logic                   r_add_vld;
    logic                   r_dat_rdy;
    logic                   r_din_vld;
    logic                   r_acc_done;
    logic [CNT_DW-1:0]      r_cnt;

    logic [c_SW-1:0]        w_op_a;
    logic [c_SW-1:0]        w_op_b;
    logic [c_SW-1:0]        w_sum;
    logic                   w_ovf;
    logic [ORAM_DAT_DW-1:0] w_sat;
    logic                   w_unused_lst;

    // One shared adder/clamp: in IDLE it saturates the incoming psum alone
    // (clear path), in WT it adds the registered psum to the read word.
    always_comb begin
        w_op_a = '0;
        if (r_state == c_ST_WT) begin
            w_op_a = {{(c_SW-ORAM_DAT_DW){bus.ORAM_DAT_DAT[ORAM_DAT_DW-1]}}, bus.ORAM_DAT_DAT};
        end
        if (r_state == c_ST_IDLE) begin
            w_op_b = {{(c_SW-PSUM_DW){bus.PSUM_DAT[PSUM_DW-1]}}, bus.PSUM_DAT};
        end else begin
            w_op_b = {{(c_SW-PSUM_DW){r_dat[PSUM_DW-1]}}, r_dat};
        end
        w_sum = w_op_a + w_op_b;
        // Out of range when the bits above the result sign are not all equal
        w_ovf = (w_sum[c_SW-1:ORAM_DAT_DW-1] != '0) && (w_sum[c_SW-1:ORAM_DAT_DW-1] != '1);
        w_sat = w_sum[ORAM_DAT_DW-1:0];
        if (w_ovf) begin
            w_sat = w_sum[c_SW-1] ? {1'b1, {(ORAM_DAT_DW-1){1'b0}}}
                                  : {1'b0, {(ORAM_DAT_DW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_add      <= '0;
            r_dat      <= '0;
            r_lst      <= 1'b0;
            r_wdat     <= '0;
            r_psum_rdy <= 1'b1;
            r_add_vld  <= 1'b0;
            r_dat_rdy  <= 1'b0;
            r_din_vld  <= 1'b0;
            r_acc_done <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_acc_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.PSUM_VLD) begin
                        r_add      <= bus.PSUM_ADD;
                        r_dat      <= bus.PSUM_DAT;
                        r_lst      <= bus.PSUM_LST;
                        r_cnt      <= r_cnt + CNT_DW'(1);
                        r_psum_rdy <= 1'b0;
                        if (bus.PSUM_CLR) begin
                            r_wdat    <= w_sat;
                            r_din_vld <= 1'b1;
                            r_state   <= c_ST_WR;
                        end else begin
                            r_add_vld <= 1'b1;
                            r_state   <= c_ST_RD;
                        end
                    end
                end
                c_ST_RD: begin
                    if (bus.ORAM_ADD_RDY) begin
                        r_add_vld <= 1'b0;
                        r_dat_rdy <= 1'b1;
                        r_state   <= c_ST_WT;
                    end
                end
                c_ST_WT: begin
                    if (bus.ORAM_DAT_VLD) begin
                        r_wdat    <= w_sat;
                        r_dat_rdy <= 1'b0;
                        r_din_vld <= 1'b1;
                        r_state   <= c_ST_WR;
                    end
                end
                default: begin
                    if (bus.ORAM_DIN_RDY) begin
                        r_din_vld  <= 1'b0;
                        r_psum_rdy <= 1'b1;
                        r_state    <= c_ST_IDLE;
                        if (r_lst) begin
                            r_acc_done <= 1'b1;
                            r_cnt      <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign w_unused_lst     = bus.ORAM_DAT_LST;

    assign bus.PSUM_RDY     = r_psum_rdy;
    assign bus.ORAM_ADD_VLD = r_add_vld;
    assign bus.ORAM_ADD_LST = r_lst;
    assign bus.ORAM_ADD_ADD = r_add;
    assign bus.ORAM_DAT_RDY = r_dat_rdy;
    assign bus.ORAM_DIN_VLD = r_din_vld;
    assign bus.ORAM_DIN_ADD = r_add;
    assign bus.ORAM_DIN_DAT = r_wdat;
    assign bus.ACC_DONE     = r_acc_done;
    assign bus.ACC_CNT      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eeg_oram_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_eeg_oram_acc
// Brief    : Directed self-checking bench for eeg_oram_acc with a RAM-lane model.
// Revision : 1.0  initial release
// ============================================================================
module tb_eeg_oram_acc;
    logic clk = 1'b0;
    logic rst_n;

    eeg_oram_acc_if #(.OMUX_ADD_AW(8), .ORAM_DAT_DW(8), .PSUM_DW(12), .CNT_DW(16)) bus ();

    eeg_oram_acc #(.OMUX_ADD_AW(8), .ORAM_DAT_DW(8), .PSUM_DW(12), .CNT_DW(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_err = 0;
    int         n_chk = 0;
    logic [7:0] mem [0:255];

    int         t_add_cyc, t_din_cyc, t_ret, t_both, t_unstable, t_writes;
    logic [7:0] t_rd_add, t_wadd, t_wdat;
    logic       t_add_lst;
    logic [15:0] t_cnt1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one psum and plays the RAM lane until the write is accepted.
    task automatic run_psum(input logic [7:0] add, input logic [11:0] dat, input logic clr,
                            input logic lst, input int add_stall, input int dat_dly,
                            input int din_stall);
        int cyc;
        int as_left, dd_left, ds_left;
        bit rd_wait, wr_acc;
        as_left = add_stall; dd_left = dat_dly; ds_left = din_stall;
        rd_wait = 0; wr_acc = 0;
        t_add_cyc = -1; t_din_cyc = -1; t_both = 0; t_unstable = 0; t_writes = 0;
        t_rd_add = '0; t_wadd = '0; t_wdat = '0; t_add_lst = 1'b0;
        check("psum_rdy_idle", 32'(bus.PSUM_RDY), 32'd1);
        bus.PSUM_VLD = 1'b1; bus.PSUM_ADD = add; bus.PSUM_DAT = dat;
        bus.PSUM_CLR = clr;  bus.PSUM_LST = lst;
        tick();
        bus.PSUM_VLD = 1'b0;
        cyc = 1;
        t_cnt1 = bus.ACC_CNT;
        while (!wr_acc && cyc < 60) begin
            bus.ORAM_DAT_VLD = 1'b0;
            if (rd_wait) begin
                if (!bus.ORAM_DAT_RDY) t_unstable++;
                if (dd_left > 0) dd_left--;
                else begin
                    bus.ORAM_DAT_VLD = 1'b1;
                    bus.ORAM_DAT_DAT = mem[t_rd_add];
                    rd_wait = 0;
                end
            end
            if (bus.ORAM_ADD_VLD && bus.ORAM_DIN_VLD) t_both++;
            if (bus.ORAM_ADD_VLD) begin
                if (t_add_cyc < 0) begin
                    t_add_cyc = cyc; t_rd_add = bus.ORAM_ADD_ADD; t_add_lst = bus.ORAM_ADD_LST;
                end else if (bus.ORAM_ADD_ADD !== t_rd_add || bus.ORAM_ADD_LST !== t_add_lst) begin
                    t_unstable++;
                end
                if (as_left > 0) begin bus.ORAM_ADD_RDY = 1'b0; as_left--; end
                else begin bus.ORAM_ADD_RDY = 1'b1; rd_wait = 1; end
            end else begin
                bus.ORAM_ADD_RDY = 1'b1;
            end
            if (bus.ORAM_DIN_VLD) begin
                if (t_din_cyc < 0) begin
                    t_din_cyc = cyc; t_wadd = bus.ORAM_DIN_ADD; t_wdat = bus.ORAM_DIN_DAT;
                end else if (bus.ORAM_DIN_ADD !== t_wadd || bus.ORAM_DIN_DAT !== t_wdat) begin
                    t_unstable++;
                end
                if (ds_left > 0) begin bus.ORAM_DIN_RDY = 1'b0; ds_left--; end
                else begin
                    bus.ORAM_DIN_RDY = 1'b1; wr_acc = 1; t_writes++;
                    mem[t_wadd] = t_wdat;
                end
            end
            tick();
            cyc++;
        end
        bus.ORAM_ADD_RDY = 1'b1; bus.ORAM_DIN_RDY = 1'b1; bus.ORAM_DAT_VLD = 1'b0;
        t_ret = cyc;
        check("write_timeout", 32'(wr_acc), 32'd1);
        check("psum_rdy_back", 32'(bus.PSUM_RDY), 32'd1);
        check("din_vld_drop", 32'(bus.ORAM_DIN_VLD), 32'd0);
        check("acc_done", 32'(bus.ACC_DONE), 32'(lst));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int hits;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        bus.PSUM_VLD = 1'b0; bus.PSUM_ADD = '0; bus.PSUM_DAT = '0;
        bus.PSUM_CLR = 1'b0; bus.PSUM_LST = 1'b0;
        bus.ORAM_ADD_RDY = 1'b1; bus.ORAM_DAT_VLD = 1'b0; bus.ORAM_DAT_LST = 1'b0;
        bus.ORAM_DAT_DAT = '0; bus.ORAM_DIN_RDY = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        check("rst_psum_rdy", 32'(bus.PSUM_RDY), 32'd1);
        check("rst_add_vld", 32'(bus.ORAM_ADD_VLD), 32'd0);
        check("rst_din_vld", 32'(bus.ORAM_DIN_VLD), 32'd0);
        check("rst_dat_rdy", 32'(bus.ORAM_DAT_RDY), 32'd0);
        check("rst_acc_done", 32'(bus.ACC_DONE), 32'd0);
        check("rst_acc_cnt", 32'(bus.ACC_CNT), 32'd0);
        check("rst_din_dat", 32'(bus.ORAM_DIN_DAT), 32'd0);
        check("rst_add_add", 32'(bus.ORAM_ADD_ADD), 32'd0);

        // Clear path
        run_psum(8'd3, 12'd5, 1'b1, 1'b0, 0, 0, 0);
        check("clr_din_cyc", t_din_cyc, 1);
        check("clr_wadd", 32'(t_wadd), 32'd3);
        check("clr_wdat", 32'(t_wdat), 32'd5);
        check("clr_no_read", t_add_cyc, -1);
        check("clr_ret", t_ret, 2);
        check("clr_cnt", 32'(t_cnt1), 32'd1);

        // Positive saturation: 100 + 30
        mem[7] = 8'd100;
        run_psum(8'd7, 12'd30, 1'b0, 1'b0, 0, 0, 0);
        check("pos_add_cyc", t_add_cyc, 1);
        check("pos_rd_add", 32'(t_rd_add), 32'd7);
        check("pos_add_lst", 32'(t_add_lst), 32'd0);
        check("pos_din_cyc", t_din_cyc, 3);
        check("pos_wdat", 32'(t_wdat), 32'h7F);
        check("pos_ret", t_ret, 4);
        check("pos_cnt", 32'(t_cnt1), 32'd2);

        // Negative saturation: -100 + -50
        mem[2] = 8'h9C;
        run_psum(8'd2, 12'hFCE, 1'b0, 1'b0, 0, 0, 0);
        check("neg_wdat", 32'(t_wdat), 32'h80);
        check("neg_wadd", 32'(t_wadd), 32'd2);

        // Normal add: 10 + -3
        mem[2] = 8'd10;
        run_psum(8'd2, 12'hFFD, 1'b0, 1'b0, 0, 0, 0);
        check("norm_wdat", 32'(t_wdat), 32'h07);

        // Clear-path clamps at both extremes, and an in-range negative
        run_psum(8'd4, 12'h7FF, 1'b1, 1'b0, 0, 0, 0);
        check("clr_max_wdat", 32'(t_wdat), 32'h7F);
        run_psum(8'd4, 12'h800, 1'b1, 1'b0, 0, 0, 0);
        check("clr_min_wdat", 32'(t_wdat), 32'h80);
        run_psum(8'd4, 12'hFFB, 1'b1, 1'b0, 0, 0, 0);
        check("clr_neg_wdat", 32'(t_wdat), 32'hFB);

        // Back-pressure on every channel, last psum of a tile
        mem[5] = 8'd20;
        run_psum(8'd5, 12'd7, 1'b0, 1'b1, 2, 3, 3);
        check("bp_add_cyc", t_add_cyc, 1);
        check("bp_rd_add", 32'(t_rd_add), 32'd5);
        check("bp_add_lst", 32'(t_add_lst), 32'd1);
        check("bp_din_cyc", t_din_cyc, 8);
        check("bp_ret", t_ret, 12);
        check("bp_wdat", 32'(t_wdat), 32'd27);
        check("bp_unstable", t_unstable, 0);
        check("bp_vld_overlap", t_both, 0);
        check("bp_writes", t_writes, 1);
        check("bp_cnt_zero", 32'(bus.ACC_CNT), 32'd0);

        // Reset while waiting for read data
        mem[6] = 8'd50;
        bus.PSUM_VLD = 1'b1; bus.PSUM_ADD = 8'd6; bus.PSUM_DAT = 12'd1;
        bus.PSUM_CLR = 1'b0; bus.PSUM_LST = 1'b0;
        tick();
        bus.PSUM_VLD = 1'b0;
        check("mid_rd_vld", 32'(bus.ORAM_ADD_VLD), 32'd1);
        tick();
        check("mid_wt_rdy", 32'(bus.ORAM_DAT_RDY), 32'd1);
        rst_n = 1'b0;
        #2;
        check("mid_psum_rdy", 32'(bus.PSUM_RDY), 32'd1);
        check("mid_dat_rdy", 32'(bus.ORAM_DAT_RDY), 32'd0);
        check("mid_add_vld", 32'(bus.ORAM_ADD_VLD), 32'd0);
        check("mid_cnt", 32'(bus.ACC_CNT), 32'd0);
        bus.ORAM_DAT_VLD = 1'b1; bus.ORAM_DAT_DAT = mem[6];
        tick();
        bus.ORAM_DAT_VLD = 1'b0;
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.ORAM_DIN_VLD || bus.ORAM_ADD_VLD) hits++;
            tick();
        end
        check("mid_no_write", hits, 0);
        check("mid_idle", 32'(bus.PSUM_RDY), 32'd1);

        // Same-address burst: clear to 0 then four +1, last flagged
        run_psum(8'd9, 12'd0, 1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_psum(8'd9, 12'd1, 1'b0, 1'b0, 0, 0, 0);
        check("burst_cnt4", 32'(bus.ACC_CNT), 32'd4);
        run_psum(8'd9, 12'd1, 1'b0, 1'b1, 0, 0, 0);
        check("burst_cnt5", 32'(t_cnt1), 32'd5);
        check("burst_wdat", 32'(t_wdat), 32'd4);
        check("burst_cnt_clr", 32'(bus.ACC_CNT), 32'd0);
        tick();
        check("burst_done_once", 32'(bus.ACC_DONE), 32'd0);
        check("burst_mem9", 32'(mem[9]), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
